vga_console_writer: RTL and testbench
=====================================

Name: vga_console_writer

Overview:
- Memory-mapped text console feeding the VgaDisplay character-RAM write port (wen / 12-bit addr / 8-bit char), upstream of VgaDisplay and alternative to the debugger overlay.
- CPU stores characters to a TX register. The block buffers them in a FIFO, tracks a cursor, interprets control characters, and emits one display write per cycle max.
- Also provides a hardware clear-screen sequencer.

Parameters:
- BASE_ADDR, 32'hFFFF_0100, byte address of TX register; CTRL at BASE_ADDR+4
- COLS, 80, characters per row
- ROWS, 30, rows on screen; ROWS*COLS must be <= 4096
- FIFO_DEPTH, 16, TX FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock (clk_100m domain)
- rst  in  1  asynchronous reset, active-low
- mem_wen  in  1  CPU data-memory store strobe
- dmem_addr  in  32  CPU store address
- dmem_o_data  in  32  CPU store data; bits [7:0] used
- display_wen  out  1  character RAM write enable
- display_w_addr  out  12  cell address = row*COLS+col
- display_w_data  out  8  character code
- tx_ready  out  1  FIFO not full
- busy  out  1  FIFO non-empty or FSM not IDLE
- overflow  out  1  sticky: a TX store was dropped

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; cursor row=0, col=0; FSM=IDLE.
  - display_wen=0, display_w_addr=0, display_w_data=0.
  - tx_ready=1, busy=0, overflow=0.
  - Character RAM contents untouched.
- Decode:
  - Full 32-bit compare.
  - TX store = mem_wen && dmem_addr==BASE_ADDR.
  - CTRL store = mem_wen && dmem_addr==BASE_ADDR+4.
- TX store:
  - Pushes dmem_o_data[7:0] if FIFO not full.
  - If full: data dropped, overflow<=1.
  - Simultaneous push and pop on a full FIFO: push accepted.
- CTRL store:
  - bit0=1 requests clear; latched into clear_pend.
  - bit1=1 clears overflow.
  - Both bits may be set together.
- All display outputs are registered. display_wen is high for exactly one cycle per write.
- FSM states: IDLE, CLEAR, ROWCLR (ROWCLR only with the optional feature).
- IDLE priority 1: if clear_pend, go to CLEAR with clr_idx=0 and clear clear_pend.
- IDLE priority 2: otherwise, if FIFO non-empty, pop one byte c and act in the same edge:
  - 0x20..0x7E: write c at (row,col); then col+1. If col==COLS-1: col=0, row advances.
  - 0x0A: col=0, row advances; no write.
  - 0x0D: col=0; no write.
  - 0x08: if col>0, col-1 and write 0x20 at the new position; if col==0, nothing.
  - Any other code: discarded; no write, cursor unchanged.
- Row advance: row+1; row ROWS-1 wraps to 0 (no scrolling).
- Latency:
  - Store sampled at edge N, printable char, FSM IDLE and FIFO empty.
  - Pop at edge N+1; display_wen high for the cycle following edge N+1.
  - Sustained throughput: 1 char/cycle.
- CLEAR:
  - Each cycle writes 0x20 at clr_idx, then clr_idx+1.
  - After writing ROWS*COLS-1: cursor=(0,0), go to IDLE.
  - Duration: ROWS*COLS cycles.
  - FIFO keeps accepting during CLEAR and is not drained.
  - A clear request arriving during CLEAR latches clear_pend and causes a second full clear afterwards.
- busy = FSM!=IDLE or FIFO non-empty or clear_pend.
- tx_ready = !full, combinational from FIFO count.
- Reset mid-CLEAR or mid-ROWCLR: abort immediately to reset state; partially cleared RAM is left as is.

Optional Feature:
- Macro: VGA_CONSOLE_ROWCLR_EN
- Defined: every row advance (newline, wrap, row wrap to 0) enters ROWCLR.
  - Writes 0x20 to the COLS cells of the new row, one per cycle, col 0 first.
  - Then returns to IDLE with cursor at (new row, 0).
  - No FIFO pops during ROWCLR.
  - A pending clear is serviced after ROWCLR completes.
- Undefined: ROWCLR state is absent; row advance takes no extra cycles and old row content remains.

Test Plan:
- Reset, store 0x41 to BASE_ADDR -> two edges later one-cycle display_wen, addr 0, data 0x41; cursor col=1.
- Store 80 printable chars, then 0x42 -> 0x42 written at addr 80; last of the 80 at addr 79.
- Store 0x41, 0x08, 0x0A, 0x43 -> writes: addr0=0x41, addr0=0x20, addr80=0x43; 0x07 store produces no write.
- Store 20 chars back-to-back with FIFO_DEPTH=16 while CTRL clear is running -> overflow=1, tx_ready=0, exactly 16 chars written after the 2400-cycle clear completes, first at addr 0.
- Write CTRL=1 -> 2400 consecutive display_wen cycles, addrs 0..2399, data 0x20; busy falls after; assert rst low at cycle 1000 of a second clear -> outputs zero immediately, no further writes.
- With VGA_CONSOLE_ROWCLR_EN: from (29,79) store 0x41 then 0x5A -> 0x41 at 2399, then 80 writes of 0x20 at addrs 0..79, then 0x5A at addr 0.

Source files
------------

// File: rtl/vga_console_writer.sv
`default_nettype none
// =============================================================================
// vga_console_writer : memory-mapped text console feeding the VGA char-RAM port.
// Optional macro VGA_CONSOLE_ROWCLR_EN blanks each newly entered row.  Rev 1.0
// =============================================================================
module vga_console_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_o_data,
    output logic        display_wen,
    output logic [11:0] display_w_addr,
    output logic [7:0]  display_w_data,
    output logic        tx_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int              RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [31:0]     CTRL_ADDR = BASE_ADDR + 32'd4;
    localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [11:0]     CELL_LAST = 12'(ROWS * COLS - 1);
    localparam logic [7:0]      SPACE     = 8'h20;
`ifdef VGA_CONSOLE_ROWCLR_EN
    localparam logic [11:0]     ROWCLR_LAST = 12'(COLS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1
`ifdef VGA_CONSOLE_ROWCLR_EN
        , S_ROWCLR = 2'd2
`endif
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [11:0]     clr_idx_q;
    logic            clear_pend_q;
    logic            overflow_q;
    logic            display_wen_q;
    logic [11:0]     display_w_addr_q;
    logic [7:0]      display_w_data_q;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    logic            tx_store;
    logic            ctrl_store;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic [7:0]      pop_char;
    logic            printable;
    logic            row_adv;
    logic            unused_data;

    function automatic logic [11:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return 12'(r) * 12'(COLS) + 12'(c);
    endfunction

    function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
        return (r == ROW_LAST) ? '0 : r + RW'(1);
    endfunction

    assign tx_store    = mem_wen && (dmem_addr == BASE_ADDR);
    assign ctrl_store  = mem_wen && (dmem_addr == CTRL_ADDR);
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    // A pending clear outranks draining the FIFO.
    assign pop         = (state_q == S_IDLE) && !clear_pend_q && !fifo_empty;
    assign push        = tx_store && (!fifo_full || pop);
    assign pop_char    = fifo_mem[rd_ptr_q];
    assign printable   = (pop_char >= 8'h20) && (pop_char <= 8'h7E);
    assign row_adv     = pop && ((printable && (col_q == COL_LAST)) || (pop_char == 8'h0A));
    assign unused_data = ^dmem_o_data[31:8];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dmem_o_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            row_q            <= '0;
            col_q            <= '0;
            clr_idx_q        <= '0;
            clear_pend_q     <= 1'b0;
            overflow_q       <= 1'b0;
            display_wen_q    <= 1'b0;
            display_w_addr_q <= '0;
            display_w_data_q <= '0;
        end else begin
            display_wen_q <= 1'b0;
            if (ctrl_store && dmem_o_data[1]) overflow_q <= 1'b0;
            if (tx_store && fifo_full && !pop) overflow_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (clear_pend_q) begin
                        clear_pend_q <= 1'b0;
                        clr_idx_q    <= '0;
                        state_q      <= S_CLEAR;
                    end else if (pop) begin
                        if (printable) begin
                            display_wen_q    <= 1'b1;
                            display_w_addr_q <= cell_addr(row_q, col_q);
                            display_w_data_q <= pop_char;
                            col_q            <= (col_q == COL_LAST) ? '0 : col_q + CW'(1);
                        end else if ((pop_char == 8'h0A) || (pop_char == 8'h0D)) begin
                            col_q <= '0;
                        end else if ((pop_char == 8'h08) && (col_q != '0)) begin
                            col_q            <= col_q - CW'(1);
                            display_wen_q    <= 1'b1;
                            display_w_addr_q <= cell_addr(row_q, col_q - CW'(1));
                            display_w_data_q <= SPACE;
                        end
                        if (row_adv) begin
                            row_q <= next_row(row_q);
`ifdef VGA_CONSOLE_ROWCLR_EN
                            clr_idx_q <= '0;
                            state_q   <= S_ROWCLR;
`endif
                        end
                    end
                end
                S_CLEAR: begin
                    display_wen_q    <= 1'b1;
                    display_w_addr_q <= clr_idx_q;
                    display_w_data_q <= SPACE;
                    if (clr_idx_q == CELL_LAST) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        clr_idx_q <= clr_idx_q + 12'd1;
                    end
                end
`ifdef VGA_CONSOLE_ROWCLR_EN
                S_ROWCLR: begin
                    // row_q already holds the new row; clr_idx_q walks its columns.
                    display_wen_q    <= 1'b1;
                    display_w_addr_q <= cell_addr(row_q, '0) + clr_idx_q;
                    display_w_data_q <= SPACE;
                    if (clr_idx_q == ROWCLR_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        clr_idx_q <= clr_idx_q + 12'd1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase

            // A request landing on the same edge IDLE consumes the old one must not be lost.
            if (ctrl_store && dmem_o_data[0]) clear_pend_q <= 1'b1;
        end
    end

    assign display_wen    = display_wen_q;
    assign display_w_addr = display_w_addr_q;
    assign display_w_data = display_w_data_q;
    assign overflow       = overflow_q;
    assign tx_ready       = !fifo_full;
    assign busy           = (state_q != S_IDLE) || !fifo_empty || clear_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_console_writer.sv
`default_nettype none
// tb_vga_console_writer: scoreboard bench; expected char-RAM writes are queued
// as stimulus is driven and retired in order as display_wen pulses appear.
module tb_vga_console_writer;

    localparam logic [31:0] BASE  = 32'hFFFF_0100;
    localparam logic [31:0] CTRL  = 32'hFFFF_0104;
    localparam int          CELLS = 2400;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_wen = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_o_data = '0;
    logic        display_wen;
    logic [11:0] display_w_addr;
    logic [7:0]  display_w_data;
    logic        tx_ready;
    logic        busy;
    logic        overflow;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_count = 0;
    int  run_len = 0;
    int  max_run = 0;
    int  flow_to = 0;

    vga_console_writer dut (
        .clk           (clk),
        .rst           (rst),
        .mem_wen       (mem_wen),
        .dmem_addr     (dmem_addr),
        .dmem_o_data   (dmem_o_data),
        .display_wen   (display_wen),
        .display_w_addr(display_w_addr),
        .display_w_data(display_w_data),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (display_wen === 1'b1) begin
            wr_count = wr_count + 1;
            run_len  = run_len + 1;
            if (run_len > max_run) max_run = run_len;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write got addr=%0d data=%h, none expected", display_w_addr, display_w_data);
            end else begin
                e = exp_q.pop_front();
                if ({display_w_addr, display_w_data} !== e) begin
                    errors = errors + 1;
                    $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                             display_w_addr, display_w_data, e.a, e.d);
                end
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_q.push_back({12'(a), d});
    endtask

    task automatic exp_rowclr(input int row);
`ifdef VGA_CONSOLE_ROWCLR_EN
        for (int c = 0; c < 80; c++) expect_wr(row * 80 + c, 8'h20);
`else
        if (row < 0) $display("row %0d", row);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_wen = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
    endtask

    // Called at a negedge; the store is sampled at the following posedge.
    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
        mem_wen = 1'b1;
        dmem_addr = a;
        dmem_o_data = d;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic store_flow(input logic [7:0] d);
        for (int i = 0; i < 500 && tx_ready !== 1'b1; i++) @(negedge clk);
        if (tx_ready !== 1'b1) flow_to = flow_to + 1;
        cpu_store(BASE, {24'h0, d});
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (display_wen !== 1'b0)     begin errors++; $display("FAIL rst_wen got=%b exp=0", display_wen); end
        if (display_w_addr !== 12'd0) begin errors++; $display("FAIL rst_addr got=%h exp=000", display_w_addr); end
        if (display_w_data !== 8'd0)  begin errors++; $display("FAIL rst_data got=%h exp=00", display_w_data); end
        if (tx_ready !== 1'b1)        begin errors++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (overflow !== 1'b0)        begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_char();
        bit ok;
        do_reset();
        expect_wr(0, 8'h41);
        cpu_store(BASE, 32'h41);
        checks++;
        if (display_wen !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", display_wen); end
        @(negedge clk);
        checks += 3;
        if (display_wen !== 1'b1)     begin errors++; $display("FAIL lat_wen got=%b exp=1", display_wen); end
        if (display_w_addr !== 12'd0) begin errors++; $display("FAIL lat_addr got=%0d exp=0", display_w_addr); end
        if (display_w_data !== 8'h41) begin errors++; $display("FAIL lat_data got=%h exp=41", display_w_data); end
        @(negedge clk);
        checks++;
        if (display_wen !== 1'b0) begin errors++; $display("FAIL wen_one_cycle got=%b exp=0", display_wen); end
        expect_wr(1, 8'h42);
        cpu_store(BASE, 32'hAB12_3442);
        wait_drain(100, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL single_drain got=%0d pending exp=0", exp_q.size()); end
    endtask

    task automatic test_line_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 80; i++) expect_wr(i, 8'(33 + i));
        exp_rowclr(1);
        expect_wr(80, 8'h42);
        for (int i = 0; i < 80; i++) cpu_store(BASE, 32'(33 + i));
        cpu_store(BASE, 32'h42);
        wait_drain(400, ok);
        checks += 2;
        if (ok !== 1'b1)       begin errors++; $display("FAIL wrap_drain got=%0d pending exp=0", exp_q.size()); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_control_chars();
        bit ok;
        logic [7:0] seq [16] = '{8'h41, 8'h08, 8'h0A, 8'h43, 8'h07, 8'h44, 8'h0D, 8'h45,
                                 8'h0D, 8'h08, 8'h46, 8'h7F, 8'h1F, 8'h7E, 8'h00, 8'h1B};
        do_reset();
        expect_wr(0, 8'h41);
        expect_wr(0, 8'h20);
        exp_rowclr(1);
        expect_wr(80, 8'h43);
        expect_wr(81, 8'h44);
        expect_wr(80, 8'h45);
        expect_wr(80, 8'h46);
        expect_wr(81, 8'h7E);
        for (int i = 0; i < 16; i++) cpu_store(BASE, {24'h0, seq[i]});
        cpu_store(BASE + 32'd8, 32'h58);
        cpu_store(CTRL, 32'h0);
        dmem_addr = BASE;
        dmem_o_data = 32'h59;
        @(negedge clk);
        wait_drain(400, ok);
        checks += 2;
        if (ok !== 1'b1)       begin errors++; $display("FAIL ctrl_drain got=%0d pending exp=0", exp_q.size()); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL ctrl_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_clear_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < CELLS; i++) expect_wr(i, 8'h20);
        for (int i = 0; i < 16; i++) expect_wr(i, 8'(8'h61 + i));
        max_run = 0;
        cpu_store(CTRL, 32'h1);
        for (int i = 0; i < 20; i++) cpu_store(BASE, 32'(8'h61 + i));
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovf_tx_ready got=%b exp=0", tx_ready); end
        if (busy !== 1'b1)     begin errors++; $display("FAIL ovf_busy got=%b exp=1", busy); end
        wait_drain(6000, ok);
        checks += 2;
        if (ok !== 1'b1)     begin errors++; $display("FAIL clear_drain got=%0d pending exp=0", exp_q.size()); end
        if (max_run < CELLS) begin errors++; $display("FAIL clear_run got=%0d exp>=%0d", max_run, CELLS); end
        cpu_store(CTRL, 32'h2);
        checks += 2;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL ovf_tx_ready_after got=%b exp=1", tx_ready); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_double_clear();
        bit ok;
        int base;
        do_reset();
        base = wr_count;
        for (int i = 0; i < 2 * CELLS; i++) expect_wr(i % CELLS, 8'h20);
        cpu_store(CTRL, 32'h1);
        repeat (10) @(negedge clk);
        cpu_store(CTRL, 32'h3);
        wait_drain(6000, ok);
        checks += 2;
        if (ok !== 1'b1) begin errors++; $display("FAIL dbl_drain got=%0d pending exp=0", exp_q.size()); end
        if (wr_count - base != 2 * CELLS) begin
            errors++; $display("FAIL dbl_count got=%0d exp=%0d", wr_count - base, 2 * CELLS);
        end
    endtask

    task automatic test_clear_abort();
        int base;
        do_reset();
        base = wr_count;
        for (int i = 0; i < CELLS; i++) expect_wr(i, 8'h20);
        cpu_store(CTRL, 32'h1);
        for (int i = 0; i < 1200 && (wr_count - base) < 1000; i++) @(negedge clk);
        checks++;
        if ((wr_count - base) < 1000) begin errors++; $display("FAIL abort_reach got=%0d exp>=1000", wr_count - base); end
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (display_wen !== 1'b0)     begin errors++; $display("FAIL abort_wen got=%b exp=0", display_wen); end
        if (display_w_addr !== 12'd0) begin errors++; $display("FAIL abort_addr got=%0d exp=0", display_w_addr); end
        if (display_w_data !== 8'd0)  begin errors++; $display("FAIL abort_data got=%h exp=00", display_w_data); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = wr_count;
        repeat (100) @(negedge clk);
        checks++;
        if (wr_count != base) begin errors++; $display("FAIL abort_quiet got=%0d writes exp=0", wr_count - base); end
    endtask

    task automatic test_wrap_bottom();
        bit ok;
        do_reset();
        flow_to = 0;
        for (int r = 1; r < 30; r++) exp_rowclr(r);
        for (int i = 0; i < 79; i++) expect_wr(2320 + i, 8'(8'h30 + i % 10));
        expect_wr(2399, 8'h41);
        exp_rowclr(0);
        expect_wr(0, 8'h5A);
        expect_wr(1, 8'h5B);
        for (int r = 0; r < 29; r++) store_flow(8'h0A);
        for (int i = 0; i < 79; i++) store_flow(8'(8'h30 + i % 10));
        store_flow(8'h41);
        store_flow(8'h5A);
        store_flow(8'h5B);
        wait_drain(8000, ok);
        checks += 3;
        if (ok !== 1'b1)       begin errors++; $display("FAIL bottom_drain got=%0d pending exp=0", exp_q.size()); end
        if (flow_to != 0)      begin errors++; $display("FAIL bottom_flow got=%0d timeouts exp=0", flow_to); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL bottom_overflow got=%b exp=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_line_wrap();
        test_control_chars();
        test_clear_overflow();
        test_double_clear();
        test_clear_abort();
        test_wrap_bottom();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
